game_banner_ctrl: RTL
=====================

Name: game_banner_ctrl

Overview:
- End-of-game banner sequencer; sits directly upstream of the color mapper and consumes the per-pixel outputs of the win and lose text generators.
- Tracks game phase: PLAY, WIN or LOSE. Times the banner display in VGA frames.
- Gates the text pixel flags so only the correct banner is drawn.
- Arms and issues a one-cycle restart request back to the game logic.

Parameters:
- HOLD_FRAMES, 120, frames a banner must be shown before restart_key is honoured (2 s at 60 Hz); legal range 1..1023.
- BLINK_FRAMES, 15, frames per blink half-period (used only with the optional feature); legal range 1..255.

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  VGA vertical sync, level signal in the Clk domain; a frame tick is its rising edge
- game_won  in  1  level, game logic reports the win condition
- game_lost  in  1  level, game logic reports a collision/loss
- restart_key  in  1  level, decoded keyboard restart key
- is_win_text  in  1  pixel belongs to "WIN" glyphs (combinational from DrawX/DrawY)
- is_lose_text  in  1  pixel belongs to "GAME OVER" glyphs (combinational from DrawX/DrawY)
- show_text  out  1  pixel is banner text; consumed by the color mapper
- text_sel  out  1  0 = lose palette, 1 = win palette
- game_active  out  1  1 only in PLAY; freezes stickman/obstacle motion when 0
- restart_pulse  out  1  one-Clk pulse requesting a game reset

Behaviour:
- Clock and reset: one clock Clk; Reset is synchronous and active-high. All state is updated on the rising edge of Clk.
- Frame tick:
  - fc_d <= frame_clk each cycle.
  - frame_tick = frame_clk & ~fc_d, exactly one Clk cycle per frame.
  - fc_d resets to 0. A frame_clk already high at reset release therefore counts as a tick.
- State register, 2 bits: PLAY=0, WIN=1, LOSE=2. Value 3 is illegal and recovers to PLAY on the next clock.
- Reset effect: state=PLAY, hold_cnt=0, armed=0, blink_phase=1, blink_cnt=0, restart_pulse=0.
- Reset output values: show_text=0, text_sel=0, game_active=1, restart_pulse=0.
- PLAY:
  - game_lost=1 -> LOSE. game_lost has priority when both game_lost and game_won are 1 in the same cycle.
  - Otherwise game_won=1 -> WIN.
  - On either transition: hold_cnt<=0, armed<=0, blink_cnt<=0, blink_phase<=1.
- WIN / LOSE, hold counting:
  - While armed=0, hold_cnt (10 bits) increments on each frame_tick.
  - When frame_tick occurs with hold_cnt==HOLD_FRAMES-1: armed<=1 and hold_cnt stops (saturates).
  - game_won and game_lost are ignored in WIN and LOSE.
- WIN / LOSE, restart:
  - When armed=1 and restart_key=1: state<=PLAY and restart_pulse<=1 for exactly one cycle.
  - restart_key while armed=0 is ignored and is not remembered.
- Key held through arming: if restart_key is held continuously while arming completes, the restart fires on the first cycle after armed becomes 1. No release is required.
- Outputs (combinational from the registered state, zero added pixel latency):
  - game_active = (state==PLAY).
  - text_sel = (state==WIN).
  - show_text = (state==WIN & is_win_text) | (state==LOSE & is_lose_text), ANDed with blink_phase.
- Reset mid-banner: returns to PLAY in the same cycle with no restart_pulse. Banner disappears on the next pixel.

Optional Feature:
- Macro: BANNER_BLINK_EN.
- Defined:
  - In WIN or LOSE, blink_cnt (8 bits) increments on each frame_tick.
  - At blink_cnt==BLINK_FRAMES-1 on a frame_tick: blink_cnt<=0 and blink_phase toggles.
  - The banner therefore blinks with a period of 2*BLINK_FRAMES frames. Blinking continues after arming.
- Not defined: blink_cnt and blink_phase logic is absent; blink_phase is constant 1 and the banner is steady.

Test Plan:
- Reset, then 3 frame ticks with no game events -> state PLAY, game_active=1, show_text=0 for any is_win_text/is_lose_text values, restart_pulse never asserted.
- game_won and game_lost both asserted for 1 cycle in PLAY -> LOSE next cycle. is_lose_text=1 gives show_text=1, text_sel=0. is_win_text=1 alone gives show_text=0.
- HOLD_FRAMES=4, WIN entered, restart_key held from entry:
  - no pulse after ticks 1-3;
  - 4th tick sets armed; restart_pulse=1 on the next cycle for exactly 1 cycle; state PLAY.
- frame_clk held high for 100 Clk cycles -> hold_cnt increments exactly once. A second tick needs frame_clk low, then high.
- Reset asserted in LOSE with armed=1 and restart_key=1 -> PLAY, restart_pulse=0, game_active=1 the following cycle.
- With BANNER_BLINK_EN and BLINK_FRAMES=2 in WIN, is_win_text=1 -> show_text pattern over ticks is 1,1,0,0,1,1. Without the macro -> show_text stays 1.

Source files
------------

// File: rtl/game_banner_ctrl.sv
// End-of-game banner sequencer: tracks PLAY/WIN/LOSE, times banner display in frames,
// gates text pixels and issues a one-cycle restart pulse. Optional blinking: BANNER_BLINK_EN.
module game_banner_ctrl #(
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_FRAMES = 15
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  input  logic game_won,
  input  logic game_lost,
  input  logic restart_key,
  input  logic is_win_text,
  input  logic is_lose_text,
  output logic show_text,
  output logic text_sel,
  output logic game_active,
  output logic restart_pulse
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2
  } state_t;

  localparam logic [9:0] HOLD_LAST = 10'(HOLD_FRAMES - 1);

  state_t     state_reg, state_next;
  logic [9:0] hold_cnt_reg, hold_cnt_next;
  logic       armed_reg, armed_next;
  logic       restart_pulse_reg, restart_pulse_next;
  logic       fc_d_reg;
  logic       frame_tick;
  logic       enter_banner;
  logic       in_banner;
  logic       blink_phase;

  // A frame_clk already high at reset release counts as a tick because fc_d starts at 0.
  assign frame_tick   = frame_clk & ~fc_d_reg;
  assign enter_banner = (state_reg == PLAY) && (game_lost || game_won);
  assign in_banner    = (state_reg == WIN) || (state_reg == LOSE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg         <= PLAY;
      hold_cnt_reg      <= '0;
      armed_reg         <= 1'b0;
      restart_pulse_reg <= 1'b0;
      fc_d_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      hold_cnt_reg      <= hold_cnt_next;
      armed_reg         <= armed_next;
      restart_pulse_reg <= restart_pulse_next;
      fc_d_reg          <= frame_clk;
    end
  end

  always_comb begin
    state_next         = state_reg;
    hold_cnt_next      = hold_cnt_reg;
    armed_next         = armed_reg;
    restart_pulse_next = 1'b0;
    case (state_reg)
      PLAY: begin
        // Loss wins a tie with a simultaneous win report.
        if (game_lost) begin
          state_next    = LOSE;
          hold_cnt_next = '0;
          armed_next    = 1'b0;
        end else if (game_won) begin
          state_next    = WIN;
          hold_cnt_next = '0;
          armed_next    = 1'b0;
        end
      end
      WIN, LOSE: begin
        if (armed_reg && restart_key) begin
          state_next         = PLAY;
          restart_pulse_next = 1'b1;
        end else if (!armed_reg && frame_tick) begin
          if (hold_cnt_reg == HOLD_LAST) begin
            armed_next = 1'b1;
          end else begin
            hold_cnt_next = hold_cnt_reg + 10'd1;
          end
        end
      end
      default: state_next = PLAY;
    endcase
  end

`ifdef BANNER_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] blink_cnt_reg;
  logic       blink_phase_reg;

  always_ff @(posedge Clk) begin
    if (Reset || enter_banner) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (in_banner && frame_tick) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 8'd1;
      end
    end
  end

  assign blink_phase = blink_phase_reg;
`else
  // Steady banner: evaluates to 1 for every legal BLINK_FRAMES.
  assign blink_phase = (BLINK_FRAMES >= 1) || enter_banner || in_banner;
`endif

  assign game_active   = (state_reg == PLAY);
  assign text_sel      = (state_reg == WIN);
  assign show_text     = (((state_reg == WIN) & is_win_text) |
                          ((state_reg == LOSE) & is_lose_text)) & blink_phase;
  assign restart_pulse = restart_pulse_reg;

endmodule
